// File: rtl/lsu_mem_port_if.sv
// lsu_mem_port_if: request, data-memory bus and write-back signals of the load/store unit
interface lsu_mem_port_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_load;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [4:0]        req_rd;
  logic              mem_valid;
  logic              mem_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_wdata;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  logic [2:0]        wb_we;
  logic [4:0]        wb_a3;
  logic [31:0]       wb_wd;
  logic              done;
  logic              err;
  modport slave (
    input  req_valid, req_load, req_size, req_signed, req_addr, req_wdata, req_rd,
    input  mem_ready, mem_rvalid, mem_rdata,
    output req_ready, mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output wb_we, wb_a3, wb_wd, done, err
  );
  modport master (
    output req_valid, req_load, req_size, req_signed, req_addr, req_wdata, req_rd,
    output mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  wb_we, wb_a3, wb_wd, done, err
  );
endinterface

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: single-outstanding load/store unit turning requests into word-aligned bus transactions with byte strobes
module lsu_mem_port #(
  parameter int ADDR_W = 32
) (
  input logic           clk,
  input logic           rst,
  lsu_mem_port_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ADDR, RESP, WB} state_t;
  state_t            state_q;
  logic              load_q, signed_q;
  logic [1:0]        size_q, lane_q;
  logic [4:0]        rd_q;
  logic              mem_valid_q, mem_we_q, done_q, err_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_wstrb_q;
  logic [31:0]       mem_wdata_q, wb_wd_q;
  logic [2:0]        wb_we_q;
  logic [4:0]        wb_a3_q;
  logic              misaligned_d;
  logic [3:0]        wstrb_d;
  logic [31:0]       wdata_d, rsh_d, wb_wd_d;
  logic [2:0]        wb_we_d;
  always_comb begin
    misaligned_d = (bus.req_size == 2'b11) || (bus.req_size == 2'b01 && bus.req_addr[0])
                   || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
    wstrb_d = bus.req_load ? 4'b0000 :
              bus.req_size == 2'b00 ? 4'b0001 << bus.req_addr[1:0] :
              bus.req_size == 2'b01 ? (bus.req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_d = bus.req_size == 2'b00 ? {4{bus.req_wdata[7:0]}} :
              bus.req_size == 2'b01 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
    // halfwords are aligned, so the byte-lane shift also selects the right half
    rsh_d = bus.mem_rdata >> {lane_q, 3'b000};
    wb_wd_d = size_q == 2'b00 ? rsh_d & 32'h0000_00ff :
              size_q == 2'b01 ? rsh_d & 32'h0000_ffff : bus.mem_rdata;
    wb_we_d = size_q == 2'b00 ? (signed_q ? 3'b010 : 3'b001) :
              size_q == 2'b01 ? (signed_q ? 3'b100 : 3'b011) : 3'b101;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      load_q      <= 1'b0;
      signed_q    <= 1'b0;
      size_q      <= 2'b00;
      lane_q      <= 2'b00;
      rd_q        <= '0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= 4'b0000;
      mem_wdata_q <= '0;
      wb_we_q     <= 3'b000;
      wb_a3_q     <= '0;
      wb_wd_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wb_we_q <= 3'b000;
      case (state_q)
        IDLE: if (bus.req_valid) begin
          load_q   <= bus.req_load;
          signed_q <= bus.req_signed;
          size_q   <= bus.req_size;
          lane_q   <= bus.req_addr[1:0];
          rd_q     <= bus.req_rd;
          if (misaligned_d) begin
            err_q  <= 1'b1;
            done_q <= 1'b1;
          end else begin
            state_q     <= ADDR;
            mem_valid_q <= 1'b1;
            mem_we_q    <= !bus.req_load;
            mem_addr_q  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            mem_wstrb_q <= wstrb_d;
            mem_wdata_q <= wdata_d;
          end
        end
        ADDR: if (bus.mem_ready) begin
          mem_valid_q <= 1'b0;
          state_q     <= load_q ? RESP : IDLE;
          done_q      <= !load_q;
        end
        RESP: if (bus.mem_rvalid) begin
          wb_wd_q <= wb_wd_d;
          wb_we_q <= wb_we_d;
          wb_a3_q <= rd_q;
          done_q  <= 1'b1;
          state_q <= WB;
        end
        WB: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.req_ready = state_q == IDLE;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.wb_we     = wb_we_q;
  assign bus.wb_a3     = wb_a3_q;
  assign bus.wb_wd     = wb_wd_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: directed and randomized checks of lsu_mem_port against a behavioural model
module tb_lsu_mem_port;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  lsu_mem_port_if #(.ADDR_W(32)) bus ();
  lsu_mem_port #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  logic        o_ready0, o_we, o_stable, o_rr_end;
  int          o_vcnt, o_first_v, o_done_k, o_done_cnt, o_err_k, o_err_cnt, o_wb_cnt, o_wb_k;
  logic [31:0] o_addr, o_wdata, o_wb_wd;
  logic [3:0]  o_strb;
  logic [2:0]  o_wb_we;
  logic [4:0]  o_wb_a3;

  function automatic void model(input bit ld, input bit [1:0] sz, input bit sg, input bit [31:0] a,
      input bit [31:0] w, input bit [31:0] rdata, output bit mis, output bit [31:0] ea,
      output bit [3:0] es, output bit [31:0] ed, output bit [31:0] ewd, output bit [2:0] ecode);
    int l;
    l = int'(a % 4);
    mis = (sz == 3) || (sz == 1 && a % 2 != 0) || (sz == 2 && l != 0);
    ea = a - 32'(l);
    if (sz == 0) begin
      es = ld ? 4'h0 : 4'(1 << l);
      ed = (w & 32'hFF) * 32'h0101_0101;
      ewd = (rdata >> (8 * l)) & 32'hFF;
      ecode = sg ? 3'd2 : 3'd1;
    end else if (sz == 1) begin
      es = ld ? 4'h0 : (l >= 2 ? 4'hC : 4'h3);
      ed = (w & 32'hFFFF) * 32'h0001_0001;
      ewd = (rdata >> (8 * l)) & 32'hFFFF;
      ecode = sg ? 3'd4 : 3'd3;
    end else begin
      es = ld ? 4'h0 : 4'hF;
      ed = w;
      ewd = rdata;
      ecode = 3'd5;
    end
  endfunction

  // Entered and left at posedge+1; cycle k counts from the cycle after the accepting edge.
  task automatic drive_txn(input bit ld, input bit [1:0] sz, input bit sg, input logic [31:0] a,
      input logic [31:0] w, input logic [4:0] rd, input logic [31:0] rdata, input int rdy_dly,
      input int rv_dly, input bit noise, input bit stop_at_done);
    int rv_k = -100;
    bus.req_valid = 1'b1;
    bus.req_load = ld;
    bus.req_size = sz;
    bus.req_signed = sg;
    bus.req_addr = a;
    bus.req_wdata = w;
    bus.req_rd = rd;
    o_ready0 = bus.req_ready;
    o_vcnt = 0; o_first_v = -1; o_done_k = -1; o_done_cnt = 0; o_err_k = -1; o_err_cnt = 0;
    o_wb_cnt = 0; o_wb_k = -1; o_stable = 1'b1; o_wb_we = 3'b000; o_rr_end = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (bus.done === 1'b1) begin o_done_cnt++; if (o_done_k < 0) o_done_k = k; end
      if (bus.err === 1'b1) begin o_err_cnt++; if (o_err_k < 0) o_err_k = k; end
      if (bus.wb_we !== 3'b000) begin
        o_wb_cnt++; o_wb_k = k; o_wb_we = bus.wb_we; o_wb_a3 = bus.wb_a3; o_wb_wd = bus.wb_wd;
      end
      o_rr_end = bus.req_ready;
      if (stop_at_done && bus.done === 1'b1) break;
      if (bus.mem_valid === 1'b1) begin
        if (o_vcnt == 0) begin
          o_first_v = k; o_we = bus.mem_we; o_addr = bus.mem_addr; o_strb = bus.mem_wstrb; o_wdata = bus.mem_wdata;
        end else if ({bus.mem_we, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata} !== {o_we, o_addr, o_strb, o_wdata})
          o_stable = 1'b0;
        o_vcnt++;
        bus.mem_ready = o_vcnt > rdy_dly;
        if (bus.mem_ready && ld) rv_k = k + 1 + rv_dly;
        bus.mem_rvalid = noise && !bus.mem_ready;
        bus.mem_rdata = $urandom;
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_rvalid = (k == rv_k);
        bus.mem_rdata = (k == rv_k) ? rdata : $urandom;
      end
      if (o_done_k >= 0 && k >= o_done_k + 2) break;
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b0;
    bus.mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({bus.mem_valid, bus.mem_we, bus.mem_wstrb, bus.wb_we, bus.done, bus.err, bus.mem_addr, bus.mem_wdata, bus.wb_a3, bus.wb_wd} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b we=%b strb=%b wbwe=%b done=%b err=%b addr=%h wdata=%h a3=%h wd=%h, want all zero",
               bus.mem_valid, bus.mem_we, bus.mem_wstrb, bus.wb_we, bus.done, bus.err, bus.mem_addr, bus.mem_wdata, bus.wb_a3, bus.wb_wd);
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_store_byte();
    drive_txn(1'b0, 2'b00, 1'b0, 32'h1003, 32'hAABBCCDD, 5'd3, 32'h0, 0, 0, 1'b0, 1'b0);
    checks++;
    if ({o_we, o_addr, o_strb, o_wdata} !== {1'b1, 32'h1000, 4'b1000, 32'hDDDDDDDD}) begin
      errors++;
      $display("FAIL store_byte_bus: got we=%b addr=%h strb=%b wdata=%h want 1 00001000 1000 dddddddd", o_we, o_addr, o_strb, o_wdata);
    end
    checks++;
    if (o_first_v !== 1 || o_done_k !== 2 || o_done_cnt !== 1 || o_wb_cnt !== 0 || o_err_cnt !== 0) begin
      errors++;
      $display("FAIL store_byte_timing: got valid@%0d done@%0d dones=%0d wb=%0d errs=%0d want 1 2 1 0 0",
               o_first_v, o_done_k, o_done_cnt, o_wb_cnt, o_err_cnt);
    end
  endtask

  task automatic test_load_half_signed();
    drive_txn(1'b1, 2'b01, 1'b1, 32'h2002, $urandom, 5'd7, 32'h80011234, 0, 0, 1'b0, 1'b0);
    checks++;
    if ({o_wb_wd, o_wb_we, o_wb_a3} !== {32'h00008001, 3'b100, 5'd7}) begin
      errors++;
      $display("FAIL load_half_wb: got wd=%h we=%b a3=%0d want 00008001 100 7", o_wb_wd, o_wb_we, o_wb_a3);
    end
    checks++;
    if (o_wb_cnt !== 1 || o_wb_k !== 3 || o_done_k !== 3 || o_done_cnt !== 1) begin
      errors++;
      $display("FAIL load_half_timing: got wbcycles=%0d wb@%0d done@%0d dones=%0d want 1 3 3 1", o_wb_cnt, o_wb_k, o_done_k, o_done_cnt);
    end
    checks++;
    if ({o_we, o_addr, o_strb} !== {1'b0, 32'h2000, 4'b0000}) begin
      errors++;
      $display("FAIL load_half_bus: got we=%b addr=%h strb=%b want 0 00002000 0000", o_we, o_addr, o_strb);
    end
  endtask

  task automatic test_load_byte_word();
    logic [31:0] rw;
    drive_txn(1'b1, 2'b00, 1'b0, 32'h0001, 32'h0, 5'd9, 32'h11223344, 0, 0, 1'b0, 1'b0);
    checks++;
    if ({o_wb_wd, o_wb_we, o_wb_a3} !== {32'h00000033, 3'b001, 5'd9}) begin
      errors++;
      $display("FAIL load_byte_wb: got wd=%h we=%b a3=%0d want 00000033 001 9", o_wb_wd, o_wb_we, o_wb_a3);
    end
    rw = $urandom;
    drive_txn(1'b1, 2'b10, 1'b1, 32'h0004, 32'h0, 5'd0, rw, 0, 0, 1'b0, 1'b0);
    checks++;
    if ({o_wb_wd, o_wb_we, o_wb_a3, o_addr} !== {rw, 3'b101, 5'd0, 32'h4}) begin
      errors++;
      $display("FAIL load_word_wb: got wd=%h we=%b a3=%0d addr=%h want %h 101 0 00000004", o_wb_wd, o_wb_we, o_wb_a3, o_addr, rw);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs [3] = '{32'h0006, 32'h0003, 32'h0010};
    logic [1:0]  sizes [3] = '{2'b10, 2'b01, 2'b11};
    for (int i = 0; i < 3; i++) begin
      drive_txn(1'(i % 2), sizes[i], 1'b0, addrs[i], $urandom, 5'd4, $urandom, 0, 0, 1'b0, 1'b0);
      checks++;
      if (o_err_k !== 1 || o_done_k !== 1 || o_err_cnt !== 1 || o_done_cnt !== 1 || o_vcnt !== 0 || o_wb_cnt !== 0 || o_rr_end !== 1'b1) begin
        errors++;
        $display("FAIL misaligned_%0d: got err@%0d done@%0d errs=%0d dones=%0d valids=%0d wb=%0d ready=%b want 1 1 1 1 0 0 1",
                 i, o_err_k, o_done_k, o_err_cnt, o_done_cnt, o_vcnt, o_wb_cnt, o_rr_end);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rw;
    drive_txn(1'b0, 2'b01, 1'b0, 32'h0002, 32'h1234ABCD, 5'd1, 32'h0, 3, 0, 1'b1, 1'b0);
    checks++;
    if (o_vcnt !== 4 || o_stable !== 1'b1 || o_done_k !== 5 || {o_we, o_addr, o_strb, o_wdata} !== {1'b1, 32'h0, 4'b1100, 32'hABCDABCD}) begin
      errors++;
      $display("FAIL backpressure_store: got valids=%0d stable=%b done@%0d we=%b addr=%h strb=%b wdata=%h want 4 1 5 1 00000000 1100 abcdabcd",
               o_vcnt, o_stable, o_done_k, o_we, o_addr, o_strb, o_wdata);
    end
    rw = $urandom;
    drive_txn(1'b1, 2'b10, 1'b0, 32'h0008, 32'h0, 5'd12, rw, 2, 1, 1'b1, 1'b0);
    checks++;
    if (o_wb_wd !== rw || o_wb_cnt !== 1 || o_done_k !== 6 || o_stable !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_load: got wd=%h wb=%0d done@%0d stable=%b want %h 1 6 1", o_wb_wd, o_wb_cnt, o_done_k, o_stable, rw);
    end
  endtask

  task automatic test_reset_in_resp();
    int bad = 0;
    bus.req_valid = 1'b1; bus.req_load = 1'b1; bus.req_size = 2'b10; bus.req_signed = 1'b0;
    bus.req_addr = 32'h40; bus.req_rd = 5'd5;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checks++;
    if (bus.mem_valid !== 1'b1) begin errors++; $display("FAIL resp_reset_valid: got %b want 1", bus.mem_valid); end
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    rst = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (bus.wb_we !== 3'b000 || bus.done !== 1'b0 || bus.mem_valid !== 1'b0 || bus.req_ready !== 1'b1) bad++;
      @(posedge clk); #1;
      bus.mem_rvalid = 1'b0;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL resp_reset_drop: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_back_to_back();
    drive_txn(1'b0, 2'b10, 1'b0, 32'h0100, 32'h55AA33CC, 5'd2, 32'h0, 0, 0, 1'b0, 1'b1);
    checks++;
    if (o_done_k !== 2 || o_rr_end !== 1'b1 || {o_addr, o_strb, o_wdata} !== {32'h100, 4'hF, 32'h55AA33CC}) begin
      errors++;
      $display("FAIL b2b_store: got done@%0d ready=%b addr=%h strb=%b wdata=%h want 2 1 00000100 1111 55aa33cc",
               o_done_k, o_rr_end, o_addr, o_strb, o_wdata);
    end
    drive_txn(1'b1, 2'b00, 1'b1, 32'h0101, 32'h0, 5'd31, 32'h0000FF00, 0, 0, 1'b0, 1'b0);
    checks++;
    if (o_ready0 !== 1'b1 || o_done_k !== 3 || {o_wb_wd, o_wb_we, o_wb_a3} !== {32'hFF, 3'b010, 5'd31}) begin
      errors++;
      $display("FAIL b2b_load: got ready=%b done@%0d wd=%h we=%b a3=%0d want 1 3 000000ff 010 31",
               o_ready0, o_done_k, o_wb_wd, o_wb_we, o_wb_a3);
    end
  endtask

  task automatic test_random();
    bit ld, sg, noise, mis;
    bit [1:0] sz;
    bit [31:0] a, w, rdata, ea, ed, ewd;
    bit [3:0] es;
    bit [2:0] ecode;
    bit [4:0] rd;
    int rdy, rv, exp_done;
    for (int n = 0; n < 80; n++) begin
      ld = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      sg = 1'($urandom_range(0, 1));
      a = $urandom & 32'hFFFF;
      if ($urandom_range(0, 3) != 0) a = (sz == 1) ? a & ~32'h1 : (sz == 2) ? a & ~32'h3 : a;
      w = $urandom; rdata = $urandom; rd = 5'($urandom_range(0, 31));
      rdy = $urandom_range(0, 3); rv = $urandom_range(0, 3); noise = 1'($urandom_range(0, 1));
      model(ld, sz, sg, a, w, rdata, mis, ea, es, ed, ewd, ecode);
      drive_txn(ld, sz, sg, a, w, rd, rdata, rdy, rv, noise, 1'b0);
      if (mis) begin
        checks++;
        if (o_err_k !== 1 || o_done_k !== 1 || o_err_cnt !== 1 || o_done_cnt !== 1 || o_vcnt !== 0 || o_wb_cnt !== 0) begin
          errors++;
          $display("FAIL rand_%0d_mis: addr=%h size=%0d got err@%0d done@%0d valids=%0d wb=%0d want 1 1 0 0",
                   n, a, sz, o_err_k, o_done_k, o_vcnt, o_wb_cnt);
        end
      end else begin
        exp_done = ld ? rdy + 3 + rv : rdy + 2;
        checks++;
        if (o_vcnt !== rdy + 1 || o_stable !== 1'b1 || o_first_v !== 1 || o_done_k !== exp_done || o_done_cnt !== 1 || o_err_cnt !== 0) begin
          errors++;
          $display("FAIL rand_%0d_timing: got valids=%0d stable=%b valid@%0d done@%0d dones=%0d errs=%0d want %0d 1 1 %0d 1 0",
                   n, o_vcnt, o_stable, o_first_v, o_done_k, o_done_cnt, o_err_cnt, rdy + 1, exp_done);
        end
        checks++;
        if ({o_we, o_addr, o_strb} !== {~ld, ea, es}) begin
          errors++;
          $display("FAIL rand_%0d_bus: got we=%b addr=%h strb=%b want %b %h %b", n, o_we, o_addr, o_strb, ~ld, ea, es);
        end
        checks++;
        if (!ld && (o_wdata !== ed || o_wb_cnt !== 0)) begin
          errors++;
          $display("FAIL rand_%0d_store: got wdata=%h wb=%0d want %h 0", n, o_wdata, o_wb_cnt, ed);
        end else if (ld && (o_wb_cnt !== 1 || o_wb_k !== exp_done || {o_wb_we, o_wb_a3, o_wb_wd} !== {ecode, rd, ewd})) begin
          errors++;
          $display("FAIL rand_%0d_load: got wb=%0d wb@%0d we=%b a3=%0d wd=%h want 1 %0d %b %0d %h",
                   n, o_wb_cnt, o_wb_k, o_wb_we, o_wb_a3, o_wb_wd, exp_done, ecode, rd, ewd);
        end
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_load = 1'b0; bus.req_size = 2'b00; bus.req_signed = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_rd = '0;
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    test_reset();
    test_store_byte();
    test_load_half_signed();
    test_load_byte_word();
    test_misaligned();
    test_backpressure();
    test_reset_in_resp();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store unit between the execute stage and the data memory bus.
- Turns a single load/store request into one word-aligned bus transaction with byte strobes.
- Loads return the selected byte/halfword/word, right-aligned, plus a write-enable code in the register file's encoding. The register file does the zero/sign extension.
- Stores complete without write-back. The block handles one transaction at a time.

Parameters:
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request offered
- req_ready  out  1  unit can accept (high only in IDLE)
- req_load  in  1  1=load, 0=store
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned)
- req_signed  in  1  sign-extend load (ignored for word/store)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- req_rd  in  5  destination register for loads
- mem_valid  out  1  bus request
- mem_ready  in  1  bus accepts request
- mem_we  out  1  1=write
- mem_addr  out  ADDR_W  word-aligned address (req_addr with [1:0]=0)
- mem_wstrb  out  4  byte lane strobes, 0 for reads
- mem_wdata  out  32  lane-replicated store data
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data, little-endian
- wb_we  out  3  write-back code: 000 none, 001 LBU, 010 LB, 011 LHU, 100 LH, 101 LW
- wb_a3  out  5  write-back register
- wb_wd  out  32  right-aligned load data, upper bits zero
- done  out  1  one-cycle pulse: transaction finished
- err  out  1  one-cycle pulse: misaligned/reserved request rejected

Behaviour:
- One clock clk; reset is synchronous and active-high on rst.
- States: IDLE, ADDR, RESP, WB.
- Reset:
  - state=IDLE.
  - mem_valid, mem_we, mem_wstrb, wb_we, done, err = 0.
  - mem_addr, mem_wdata, wb_a3, wb_wd = 0.
- IDLE:
  - req_ready=1. Handshake is req_valid & req_ready; all request fields are registered at that edge.
  - Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size=11. Next cycle: err=1, done=1, state stays IDLE. No bus access, wb_we=000.
  - Otherwise go to ADDR.
- ADDR:
  - mem_valid=1. mem_we, mem_addr, mem_wstrb and mem_wdata stay constant until mem_ready.
  - On mem_valid & mem_ready:
    - Store: next cycle is IDLE with done=1.
    - Load: go to RESP.
- Store lanes (L = addr[1:0]):
  - Byte: wstrb = 1<<L, wdata = {4{wdata[7:0]}}.
  - Half: wstrb = 0011 (addr[1]=0) or 1100 (addr[1]=1), wdata = {2{wdata[15:0]}}.
  - Word: wstrb = 1111, wdata unchanged.
- Loads:
  - mem_we=0, wstrb=0000.
  - mem_rvalid is sampled only in RESP; the earliest sample is the cycle after the address handshake. rvalid in IDLE or ADDR is ignored.
- RESP, on mem_rvalid, capture then go to WB:
  - Byte: wb_wd = {24'b0, rdata[8L+7:8L]}.
  - Half: wb_wd = {16'b0, rdata[16*addr[1]+15:16*addr[1]]}.
  - Word: wb_wd = rdata.
- WB (exactly one cycle):
  - wb_we = code from size/signed: byte 001/010, half 011/100, word 101.
  - wb_a3 = req_rd, done=1, req_ready=0.
  - Then IDLE; wb_we returns to 000.
  - rd=0 is still written; the register file masks reads of r0.
- Latency with zero-wait memory:
  - Store: accept T, mem_valid T+1, done T+2.
  - Load: accept T, mem_valid T+1, rvalid T+2, WB/done T+3.
  - Next request can be accepted in the done cycle for stores; for loads, the cycle after WB.
- wb_we is nonzero only in WB. done and err never last more than one cycle.
- Reset in any state: next cycle is IDLE, mem_valid=0, wb_we=0. Pending rvalid is dropped; no write-back.

Test Plan:
- Store byte: addr=0x1003, wdata=0xAABBCCDD -> mem_addr=0x1000, wstrb=1000, wdata=0xDDDDDDDD, mem_we=1; done 2 cycles after accept; wb_we stays 000.
- Signed half load: addr=0x2002, rdata=0x80011234, rd=7 -> wb_wd=0x00008001, wb_we=100, wb_a3=7, all for one cycle; done in the same cycle.
- Unsigned byte load: addr=0x0001, rdata=0x11223344 -> wb_wd=0x00000033, wb_we=001. Word load: addr=0x0004 -> wb_wd=rdata, wb_we=101.
- Misaligned word: addr=0x0006 -> err=1 and done=1 next cycle, mem_valid never rises, wb_we=000, req_ready=1 again.
- Backpressure: mem_ready low for 3 cycles during a half store at 0x0002 -> mem_valid/addr/wstrb=1100/wdata stable for all 4 cycles; a rvalid pulse during ADDR is ignored.
- Reset while in RESP, then mem_rvalid=1 -> no write-back, IDLE, req_ready=1. Back-to-back store then load both complete in order.
